// File: rtl/obi_rr_arbiter_if.sv
// OBI bundle carrying LANES independent request/response lanes packed side by side.
// Lane k uses bit k of the 1-bit fields, bits [32k+31:32k] of addr/wdata/rdata
// and bits [4k+3:4k] of be.
//
// Handshake: a lane's request is accepted in the cycle where req and gnt are
// both high. Once req is raised, the master holds req, addr, we, be and wdata
// stable until it sees gnt. Each accepted read returns exactly one rvalid beat,
// in acceptance order. Writes return nothing.
interface obi_rr_arbiter_if #(
   parameter int LANES = 1
);
   logic [LANES-1:0]    req;
   logic [LANES-1:0]    gnt;
   logic [32*LANES-1:0] addr;
   logic [LANES-1:0]    we;
   logic [4*LANES-1:0]  be;
   logic [32*LANES-1:0] wdata;
   logic [LANES-1:0]    rvalid;
   logic [32*LANES-1:0] rdata;

   modport master (
      output req, addr, we, be, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, addr, we, be, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter with round-robin fairness.
// The slave side can hold up to MAX_OUTSTANDING reads in flight. The master
// index of each accepted read is kept in an in-order FIFO, so each response
// beat is steered back to the master that issued that read.
// A request left waiting for gnt is locked onto its master. This keeps req and
// its attributes stable at the slave until the slave accepts it.
module obi_rr_arbiter #(
   parameter  int NUM_MASTERS     = 4,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int IW = $clog2(NUM_MASTERS),
   localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   obi_rr_arbiter_if.slave  mst,
   obi_rr_arbiter_if.master shr,
   output logic [CW-1:0]    outstanding_o,
   output logic             bad_state_o,
   output logic             dbg_state_o
);

   // FIFO pointer width; a single-entry FIFO still needs one pointer bit.
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   arb_state_e    r_state;
   arb_state_e    w_state_nxt;
   logic [IW-1:0] r_lock_idx;
   logic [IW-1:0] w_lock_idx_nxt;
   logic [IW-1:0] r_ptr;

   logic [IW-1:0] r_fifo [MAX_OUTSTANDING];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [IW:0]   w_scan_idx;
   logic [IW-1:0] w_rr_sel;
   logic          w_rr_found;
   logic [IW-1:0] w_sel;
   logic          w_locked;
   logic          w_enable;
   logic          w_req;
   logic          w_accept;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [IW-1:0] w_head;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Round-robin scan: first requesting master at or after r_ptr, wrapping mod N.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_sel   = '0;
      w_scan_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_scan_idx = {1'b0, r_ptr} + (IW+1)'(i);
         if (w_scan_idx >= (IW+1)'(NUM_MASTERS)) begin
            w_scan_idx = w_scan_idx - (IW+1)'(NUM_MASTERS);
         end
         if (!w_rr_found && mst.req[w_scan_idx[IW-1:0]]) begin
            w_rr_found = 1'b1;
            w_rr_sel   = w_scan_idx[IW-1:0];
         end
      end
   end

   // A locked request bypasses both the scan and the FIFO-full check. A response
   // popping the FIFO in this same cycle does not free a slot for this cycle's
   // request, so there is no combinational rvalid->req path.
   assign w_locked = (r_state == ARB_LOCKED);
   assign w_sel    = w_locked ? r_lock_idx : w_rr_sel;
   assign w_enable = w_locked || (r_count < CW'(MAX_OUTSTANDING));
   assign w_req    = rst_ni && w_enable && (w_locked || w_rr_found);
   assign w_accept = w_req && shr.gnt[0];
   assign w_push   = w_accept && !mst.we[w_sel];
   assign w_empty  = (r_count == '0);
   assign w_pop    = shr.rvalid[0] && !w_empty;
   assign w_head   = r_fifo[r_rd_ptr];

   assign outstanding_o = r_count;
   assign bad_state_o   = rst_ni && shr.rvalid[0] && w_empty;
   assign dbg_state_o   = w_locked;

   // Address phase: forward the selected master to the slave and return the slave's gnt to it.
   always_comb begin
      shr.req   = '0;
      shr.addr  = '0;
      shr.we    = '0;
      shr.be    = '0;
      shr.wdata = '0;
      mst.gnt   = '0;
      if (w_req) begin
         shr.req[0]     = 1'b1;
         shr.addr       = mst.addr[32*w_sel +: 32];
         shr.we[0]      = mst.we[w_sel];
         shr.be         = mst.be[4*w_sel +: 4];
         shr.wdata      = mst.wdata[32*w_sel +: 32];
         mst.gnt[w_sel] = shr.gnt[0];
      end
   end

   // Response phase: steer a beat to the FIFO head. A beat with nothing outstanding is dropped.
   always_comb begin
      mst.rvalid = '0;
      mst.rdata  = '0;
      if (w_pop) begin
         mst.rvalid[w_head]         = 1'b1;
         mst.rdata[32*w_head +: 32] = shr.rdata;
      end
   end

   // Lock FSM next state: lock on a stalled request, unlock once the slave accepts it.
   always_comb begin
      w_state_nxt    = r_state;
      w_lock_idx_nxt = r_lock_idx;
      if (w_req && !shr.gnt[0]) begin
         w_state_nxt    = ARB_LOCKED;
         w_lock_idx_nxt = w_sel;
      end else if (w_accept) begin
         w_state_nxt = ARB_OPEN;
      end
   end

   // Lock FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ARB_OPEN;
         r_lock_idx <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_idx <= w_lock_idx_nxt;
      end
   end

   // Round-robin pointer: after an accept, priority moves to the master after the winner.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= (w_sel == IW'(NUM_MASTERS - 1)) ? '0 : w_sel + 1'b1;
      end
   end

   // Read-ID FIFO: push the winner on an accepted read, pop on each response beat.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_fifo[i] <= '0;
         end
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
            r_wr_ptr         <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
